accel_axis_filter: RTL and testbench
====================================

Name: accel_axis_filter

Overview:
- Sits directly downstream of the SPI master's receive path.
- Consumes each received accelerometer byte (XDATA, YDATA, ZDATA) as a strobe plus byte index.
- Assembles complete X/Y/Z triplets and computes a per-axis moving average over 2^LOG2_WIN samples.
- Presents signed averaged values to the seven-segment decoders in place of raw bytes.

Parameters:
- DATA_W, 8: width of each signed axis sample, two's complement.
- LOG2_WIN, 3: log2 of the averaging window (window = 8 samples); legal range 1..5.

Ports:
- clk  in  1  system clock (SPI sclk domain).
- rst  in  1  asynchronous active-high reset.
- clear  in  1  synchronous flush of filter history.
- in_valid  in  1  one-cycle strobe: in_data is a complete received byte.
- in_idx  in  2  byte position within the burst: 0=X, 1=Y, 2=Z, 3=ignored.
- in_data  in  DATA_W  received byte, signed.
- avg_x / avg_y / avg_z  out  DATA_W each  signed window averages.
- out_valid  out  1  one-cycle pulse when the averages update.
- primed  out  1  high once the window holds 2^LOG2_WIN real samples.
- seq_err  out  1  sticky flag: a triplet arrived out of order.

Behaviour:
- Reset (async, rst=1):
  - avg_x, avg_y, avg_z, out_valid, primed and seq_err are 0.
  - Ring buffers, running sums, fill counter and capture state are cleared.
- Capture FSM, states WAIT_X, WAIT_Y, WAIT_Z:
  - in_valid with in_idx=0 in any state: latch X, go to WAIT_Y. A restart is legal and is not an error.
  - idx=1 in WAIT_Y: latch Y, go to WAIT_Z.
  - idx=2 in WAIT_Z: latch Z, issue a sample-accept, go to WAIT_X.
  - idx=1 or 2 in any other state: set seq_err, discard the byte, go to WAIT_X.
  - idx=3: ignored; no state change.
- Filter pipeline (per axis, identical):
  - Cycle T is the sample-accept cycle.
  - T+1: read the oldest ring entry at the write pointer; register the new sample.
  - T+2: sum <= sum + new - oldest; write the new sample to the ring; advance the pointer (wrap-around at 2^LOG2_WIN-1 -> 0); drive avg = sum_next >>> LOG2_WIN; assert out_valid.
  - Fixed latency of 2 cycles from the accept cycle to out_valid.
- Arithmetic:
  - sum is signed, DATA_W+LOG2_WIN bits wide, and never overflows.
  - Average uses an arithmetic right shift, so it rounds toward negative infinity.
  - The result always fits DATA_W.
- Warm-up:
  - The ring starts zeroed, so early averages ramp toward the input.
  - Fill counter saturates at 2^LOG2_WIN; primed rises in the same cycle as the out_valid that completes the window.
- Back-to-back accepts: pipelined, one per cycle sustained. No stalls and no backpressure.
- clear:
  - Same effect as reset on buffers, sums, fill counter, primed, FSM and seq_err.
  - avg_* hold their last value.
  - Any sample in flight is dropped and out_valid is not asserted for it.
  - If clear and in_valid occur in the same cycle, clear wins and the byte is discarded.
- Reset mid-triplet: partial capture is lost; the next idx=0 starts fresh.

Optional Feature:
- Macro: ACCEL_DEADBAND_EN.
- When defined: adds parameter DEADBAND (default 2). Any average with |avg| < DEADBAND is output as 0; sum and ring are unaffected; latency is unchanged.
- When undefined: averages pass through unmodified and the parameter does not exist.

Decomposition:
- Package accel_pkg:
  - enum axis_e (AXIS_X=0, AXIS_Y=1, AXIS_Z=2, AXIS_NONE=3).
  - typedef accel_sample_t: packed struct of three signed DATA_W fields.
  - Capture-state enum cap_state_e.
- Sub-module axis_mavg: ring buffer, pointer, running sum and shift for one axis; instantiated 3 times.
- The top level holds the capture FSM, fill counter, primed/seq_err, clear fan-out and the optional deadband.

Test Plan:
- After reset, send triplet X=16, Y=-8, Z=64 -> out_valid exactly 2 cycles after the Z strobe; avg_x=2, avg_y=-1, avg_z=8; primed=0.
- Send 8 identical triplets (16, -8, 64) -> on the 8th out_valid avg=(16, -8, 64) and primed=1; a 9th triplet (0, 0, 0) gives avg=(14, -7, 56).
- Single triplet X=-1, Y=1, Z=0 from reset -> avg_x=-1, avg_y=0, avg_z=0 (floor rounding).
- Bytes idx 0, then 2 -> no out_valid, seq_err=1 sticky; a following valid triplet is accepted normally.
- Two triplets sent with zero gap (Z byte of the first, then X/Y/Z of the second on consecutive cycles) -> two out_valid pulses with correct cumulative averages; a triplet sent with clear asserted on the Z cycle -> no out_valid, fill and primed reset.
- With ACCEL_DEADBAND_EN defined and DEADBAND=2: triplet (8, 15, -9) from reset gives sums (8, 15, -9) and raw averages (1, 1, -2), so avg=(0, 0, -2).

Source files
------------

// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared types for the accelerometer moving-average filter
package accel_pkg;

    localparam int ACCEL_DATA_W = 8;

    typedef enum logic [1:0] {
        AXIS_X    = 2'd0,
        AXIS_Y    = 2'd1,
        AXIS_Z    = 2'd2,
        AXIS_NONE = 2'd3
    } axis_e;

    typedef struct packed {
        logic signed [ACCEL_DATA_W-1:0] x;
        logic signed [ACCEL_DATA_W-1:0] y;
        logic signed [ACCEL_DATA_W-1:0] z;
    } accel_sample_t;

    typedef enum logic [1:0] {
        WAIT_X = 2'd0,
        WAIT_Y = 2'd1,
        WAIT_Z = 2'd2
    } cap_state_e;

endpackage

// File: rtl/accel_axis_filter_axis_mavg.sv
// rtl/accel_axis_filter_axis_mavg.sv - one-axis ring buffer, running sum and window average
module axis_mavg #(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     accept,
    input  logic                     commit,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [DATA_W-1:0] avg_next
);

    localparam int WIN = 1 << LOG2_WIN;
    localparam int SW  = DATA_W + LOG2_WIN;

    logic signed [DATA_W-1:0] ring [WIN];
    logic        [LOG2_WIN-1:0] ptr;
    logic        [LOG2_WIN-1:0] rd_ptr;
    logic signed [SW-1:0]       sum;
    logic signed [SW-1:0]       sum_next;
    logic signed [DATA_W-1:0]   new_q;
    logic signed [DATA_W-1:0]   old_q;

    // A commit in the same cycle advances the pointer, so read the slot it will point at next.
    assign rd_ptr   = commit ? ptr + LOG2_WIN'(1) : ptr;
    assign sum_next = sum + SW'(new_q) - SW'(old_q);
    // The average fits DATA_W, so this slice equals sum_next >>> LOG2_WIN (floor rounding).
    assign avg_next = sum_next[LOG2_WIN +: DATA_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN; i++) ring[i] <= '0;
            ptr   <= '0;
            sum   <= '0;
            new_q <= '0;
            old_q <= '0;
        end else if (clear) begin
            for (int i = 0; i < WIN; i++) ring[i] <= '0;
            ptr   <= '0;
            sum   <= '0;
            new_q <= '0;
            old_q <= '0;
        end else begin
            if (accept) begin
                new_q <= sample;
                old_q <= ring[rd_ptr];
            end
            if (commit) begin
                sum       <= sum_next;
                ring[ptr] <= new_q;
                ptr       <= ptr + LOG2_WIN'(1);
            end
        end
    end

endmodule

// File: rtl/accel_axis_filter.sv
// rtl/accel_axis_filter.sv - X/Y/Z triplet capture plus per-axis moving average
// Optional ACCEL_DEADBAND_EN adds parameter DEADBAND that zeroes small averages.
module accel_axis_filter
    import accel_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int LOG2_WIN = 3
`ifdef ACCEL_DEADBAND_EN
    ,
    parameter int DEADBAND = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [1:0]        in_idx,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] avg_x,
    output logic [DATA_W-1:0] avg_y,
    output logic [DATA_W-1:0] avg_z,
    output logic              out_valid,
    output logic              primed,
    output logic              seq_err
);

    localparam int               WIN     = 1 << LOG2_WIN;
    localparam logic [LOG2_WIN:0] WIN_CNT = (LOG2_WIN + 1)'(WIN);

    cap_state_e        state_q, state_d;
    logic              latch_x, latch_y, accept, err_set;
    logic [DATA_W-1:0] x_q, y_q;
    logic              v1;
    logic              commit;
    logic [LOG2_WIN:0] fill_q, fill_d;
    logic signed [DATA_W-1:0] ax_next, ay_next, az_next;

`ifdef ACCEL_DEADBAND_EN
    function automatic logic [DATA_W-1:0] shape(input logic signed [DATA_W-1:0] v);
        if (int'(v) > -DEADBAND && int'(v) < DEADBAND) begin
            return '0;
        end else begin
            return v;
        end
    endfunction
`else
    function automatic logic [DATA_W-1:0] shape(input logic signed [DATA_W-1:0] v);
        return v;
    endfunction
`endif

    always_comb begin
        state_d = state_q;
        latch_x = 1'b0;
        latch_y = 1'b0;
        accept  = 1'b0;
        err_set = 1'b0;
        if (in_valid && !clear) begin
            case (axis_e'(in_idx))
                AXIS_X: begin
                    latch_x = 1'b1;
                    state_d = WAIT_Y;
                end
                AXIS_Y: begin
                    if (state_q == WAIT_Y) begin
                        latch_y = 1'b1;
                        state_d = WAIT_Z;
                    end else begin
                        err_set = 1'b1;
                        state_d = WAIT_X;
                    end
                end
                AXIS_Z: begin
                    if (state_q == WAIT_Z) begin
                        accept = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                    state_d = WAIT_X;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= WAIT_X;
            x_q     <= '0;
            y_q     <= '0;
            seq_err <= 1'b0;
            v1      <= 1'b0;
        end else if (clear) begin
            state_q <= WAIT_X;
            x_q     <= '0;
            y_q     <= '0;
            seq_err <= 1'b0;
            v1      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (latch_x) x_q <= in_data;
            if (latch_y) y_q <= in_data;
            if (err_set) seq_err <= 1'b1;
            v1 <= accept;
        end
    end

    // Z needs no holding register: the accept cycle presents it directly on in_data.
    assign commit = v1 && !clear;
    assign fill_d = (fill_q != WIN_CNT) ? fill_q + (LOG2_WIN + 1)'(1) : fill_q;

    axis_mavg #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN)) u_mavg_x (
        .clk(clk), .rst(rst), .clear(clear), .accept(accept), .commit(commit),
        .sample(x_q), .avg_next(ax_next)
    );
    axis_mavg #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN)) u_mavg_y (
        .clk(clk), .rst(rst), .clear(clear), .accept(accept), .commit(commit),
        .sample(y_q), .avg_next(ay_next)
    );
    axis_mavg #(.DATA_W(DATA_W), .LOG2_WIN(LOG2_WIN)) u_mavg_z (
        .clk(clk), .rst(rst), .clear(clear), .accept(accept), .commit(commit),
        .sample(in_data), .avg_next(az_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q    <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
            avg_x     <= '0;
            avg_y     <= '0;
            avg_z     <= '0;
        end else if (clear) begin
            fill_q    <= '0;
            primed    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= commit;
            if (commit) begin
                fill_q <= fill_d;
                primed <= (fill_d == WIN_CNT);
                avg_x  <= shape(ax_next);
                avg_y  <= shape(ay_next);
                avg_z  <= shape(az_next);
            end
        end
    end

endmodule

// File: tb/tb_accel_axis_filter.sv
// tb/tb_accel_axis_filter.sv - directed vector bench for accel_axis_filter
module tb_accel_axis_filter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_idx = 2'd0;
    logic [7:0] in_data = 8'd0;
    logic [7:0] avg_x, avg_y, avg_z;
    logic       out_valid, primed, seq_err;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        bit rst;
        int x, y, z;
        int ex, ey, ez;
        bit ep;
    } vec_t;

    vec_t tbl[12];
    int   bi[6] = '{0, 1, 2, 0, 1, 2};
    int   bd[6] = '{8, 16, -24, 24, -16, 40};

    always #5 clk = ~clk;

    accel_axis_filter dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_idx(in_idx), .in_data(in_data),
        .avg_x(avg_x), .avg_y(avg_y), .avg_z(avg_z),
        .out_valid(out_valid), .primed(primed), .seq_err(seq_err)
    );

    function automatic int db(input int v);
`ifdef ACCEL_DEADBAND_EN
        if (v > -2 && v < 2) return 0;
`endif
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input int idx, input int d, input bit clr);
        @(negedge clk);
        in_valid = v;
        in_idx   = 2'(idx);
        in_data  = 8'(d);
        clear    = clr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic triplet_check(input string name, input int x, input int y, input int z,
                                 input int ex, input int ey, input int ez, input int ep);
        drive(1, 0, x, 0);
        drive(1, 1, y, 0);
        drive(1, 2, z, 0);
        drive(0, 3, 0, 0);
        check({name, ".ov_t1"}, int'(out_valid), 0);
        @(negedge clk);
        check({name, ".ov_t2"}, int'(out_valid), 1);
        check({name, ".avg_x"}, $signed(avg_x), db(ex));
        check({name, ".avg_y"}, $signed(avg_y), db(ey));
        check({name, ".avg_z"}, $signed(avg_z), db(ez));
        check({name, ".primed"}, int'(primed), ep);
        @(negedge clk);
        check({name, ".ov_t3"}, int'(out_valid), 0);
    endtask

    initial begin
        tbl[0] = '{1, 16, -8, 64, 2, -1, 8, 0};
        tbl[1] = '{1, -1, 1, 0, -1, 0, 0, 0};
        tbl[2] = '{1, 8, 15, -9, 1, 1, -2, 0};
        tbl[3] = '{1, 16, -8, 64, 2, -1, 8, 0};
        for (int k = 2; k <= 8; k++) tbl[k + 2] = '{0, 16, -8, 64, 2 * k, -k, 8 * k, k == 8};
        tbl[11] = '{0, 0, 0, 0, 14, -7, 56, 1};

        repeat (2) @(negedge clk);
        check("rst.avg_x", int'(avg_x), 0);
        check("rst.avg_y", int'(avg_y), 0);
        check("rst.avg_z", int'(avg_z), 0);
        check("rst.out_valid", int'(out_valid), 0);
        check("rst.primed", int'(primed), 0);
        check("rst.seq_err", int'(seq_err), 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst) do_reset();
            triplet_check($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].z,
                          tbl[i].ex, tbl[i].ey, tbl[i].ez, int'(tbl[i].ep));
        end

        // out-of-order Z after X
        do_reset();
        drive(1, 0, 5, 0);
        drive(1, 2, 7, 0);
        drive(0, 3, 0, 0);
        repeat (3) begin
            @(negedge clk);
            check("seqerr.no_ov", int'(out_valid), 0);
        end
        check("seqerr.flag", int'(seq_err), 1);
        triplet_check("seqerr.recover", 8, 8, 8, 1, 1, 1, 0);
        check("seqerr.sticky", int'(seq_err), 1);

        // two triplets with zero gap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("b2b.ov%0d", i), int'(out_valid), int'(i == 4 || i == 7));
            if (i == 4) begin
                check("b2b.a.x", $signed(avg_x), db(1));
                check("b2b.a.y", $signed(avg_y), db(2));
                check("b2b.a.z", $signed(avg_z), db(-3));
            end
            if (i == 7) begin
                check("b2b.b.x", $signed(avg_x), db(4));
                check("b2b.b.y", $signed(avg_y), db(0));
                check("b2b.b.z", $signed(avg_z), db(2));
            end
            if (i < 6) begin
                in_valid = 1'b1; in_idx = 2'(bi[i]); in_data = 8'(bd[i]);
            end else begin
                in_valid = 1'b0;
            end
        end

        // fill the window, then clear on the Z cycle
        do_reset();
        for (int k = 1; k <= 8; k++)
            triplet_check($sformatf("fill%0d", k), 16, -8, 64, 2 * k, -k, 8 * k, int'(k == 8));
        drive(1, 1, 5, 0);
        drive(0, 3, 0, 0);
        check("clr.pre_seq_err", int'(seq_err), 1);
        drive(1, 0, 1, 0);
        drive(1, 1, 2, 0);
        drive(1, 2, 3, 1);
        drive(0, 3, 0, 0);
        repeat (4) begin
            check("clr.no_ov", int'(out_valid), 0);
            @(negedge clk);
        end
        check("clr.primed", int'(primed), 0);
        check("clr.seq_err", int'(seq_err), 0);
        check("clr.hold_x", $signed(avg_x), db(16));
        check("clr.hold_y", $signed(avg_y), db(-8));
        check("clr.hold_z", $signed(avg_z), db(64));
        triplet_check("clr.fresh", 16, -8, 64, 2, -1, 8, 0);

        // clear while the sample is between accept and commit
        do_reset();
        drive(1, 0, 16, 0);
        drive(1, 1, -8, 0);
        drive(1, 2, 64, 0);
        drive(0, 3, 0, 1);
        drive(0, 3, 0, 0);
        repeat (3) begin
            check("flight.no_ov", int'(out_valid), 0);
            @(negedge clk);
        end
        check("flight.avg_x", int'(avg_x), 0);
        triplet_check("flight.after", 16, -8, 64, 2, -1, 8, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
